// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing a single uart_tx among N_REQ requesters.
// A winner's byte is latched onto tx_d_in and launched with a one-cycle
// tx_send_req. The winner gets a one-cycle ack after tx_send_ack arrives. If the
// frame hangs, a watchdog ends it and the winner gets a one-cycle err instead.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for an unmasked request; picks winner from ptr onward
// LAUNCH | tx_send_req pulse is on the line, watchdog cleared
// WAIT   | frame in flight; ends on tx_send_ack (ack) or watchdog (err)
module uart_tx_arbiter #(
  parameter  int N_REQ       = 4,
  parameter  int n           = 8,
  parameter  int f_MHz       = 50,
  parameter  int baud_rate   = 921600,
  localparam int T_baud      = f_MHz * 1000000 / baud_rate,
  localparam int TIMEOUT_CYC = 2 * T_baud * (n + 2),
  localparam int IW          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*n-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   err,
  output logic               busy,
  output logic [IW-1:0]      grant_idx,
  output logic               tx_send_req,
  output logic [n-1:0]       tx_d_in,
  input  logic               tx_send_ack
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [CW-1:0]   wd_cnt;
  logic [N_REQ-1:0] cand;
  logic [IW-1:0]   pick;
  logic            found;
  logic [N_REQ-1:0] grant_oh;
  logic [IW-1:0]   next_ptr;
  logic            wd_expired;

  // Candidates exclude the requester being acked/errored this cycle, so a
  // client that keeps req high across its ack is not immediately re-served.
  assign cand       = req & ~(ack | err);
  assign next_ptr   = (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + IW'(1);
  assign wd_expired = (wd_cnt == CW'(TIMEOUT_CYC - 1));

  // Round-robin search: first candidate at ptr, ptr+1, ... wrapping at N_REQ.
  always_comb begin
    int j;
    j     = 0;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && cand[j]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end

  // One-hot of the current winner, used for the ack/err pulses.
  always_comb begin
    grant_oh            = '0;
    grant_oh[grant_idx] = 1'b1;
  end

  // Arbitration FSM with registered outputs and frame watchdog.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ptr         <= '0;
      wd_cnt      <= '0;
      ack         <= '0;
      err         <= '0;
      busy        <= 1'b0;
      grant_idx   <= '0;
      tx_send_req <= 1'b0;
      tx_d_in     <= '0;
    end else begin
      ack         <= '0;
      err         <= '0;
      tx_send_req <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            grant_idx   <= pick;
            tx_d_in     <= req_data[int'(pick)*n +: n];
            tx_send_req <= 1'b1;
            busy        <= 1'b1;
            state       <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          wd_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          // A done pulse on the expiry cycle still counts as success.
          if (tx_send_ack) begin
            ack   <= grant_oh;
            ptr   <= next_ptr;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (wd_expired) begin
            err   <= grant_oh;
            ptr   <= next_ptr;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
